// File: rtl/seq_pkg.sv
// Shared definitions for the fetch/execute sequencer: state encodings and the
// instruction-boundary decision.
package seq_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_IO_WAIT = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_HALTED  = 3'd5
  } seq_state_e;

  // Where to go once an instruction retires: HALT beats stop beats single-step.
  function automatic seq_state_e boundary_next(input logic halt,
                                               input logic stop,
                                               input logic step_mode);
    if (halt)           return ST_HALTED;
    else if (stop)      return ST_IDLE;
    else if (step_mode) return ST_PAUSE;
    else                return ST_FETCH;
  endfunction

endpackage

// File: rtl/seq_edge.sv
// Rising-edge detector for debounced panel keys; history updates every cycle.
module seq_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic p
);

  logic q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign p = d & ~q;

endmodule

// File: rtl/seq_ctrl.sv
// Fetch/execute phase sequencer for the 8-bit model machine.
// Optional I/O timeout enabled by defining SEQ_IO_TIMEOUT_EN.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             halt_i,
  input  logic             io_i,
  input  logic             io_ack,
  output logic             sm,
  output logic             sm_en,
  output logic             running,
  output logic             paused,
  output logic             halted,
  output logic             io_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [ST_W-1:0]  state_dbg
);

  seq_state_e state, next;
  logic       start_p, step_p;
  logic       retire, to_hit, to_fire;

  seq_edge u_start_edge (.clk(clk), .rst_n(rst_n), .d(start),    .p(start_p));
  seq_edge u_step_edge  (.clk(clk), .rst_n(rst_n), .d(step_req), .p(step_p));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next;
  end

  always_comb begin
    next    = state;
    sm      = 1'b0;
    sm_en   = 1'b0;
    retire  = 1'b0;
    to_fire = 1'b0;
    case (state)
      ST_IDLE:   if (start_p) next = ST_FETCH;
      ST_FETCH: begin
        sm_en = 1'b1;
        next  = ST_EXEC;
      end
      ST_EXEC: begin
        sm = 1'b1;
        if (io_i && !io_ack) begin
          next = ST_IO_WAIT;
        end else begin
          sm_en  = 1'b1;
          retire = 1'b1;
          next   = boundary_next(halt_i, stop, step_mode);
        end
      end
      ST_IO_WAIT: begin
        sm = 1'b1;
        // An ack on the limit cycle still retires; the timeout only fires without it.
        if (io_ack) begin
          sm_en  = 1'b1;
          retire = 1'b1;
          next   = boundary_next(halt_i, stop, step_mode);
        end else if (to_hit) begin
          to_fire = 1'b1;
          next    = ST_HALTED;
        end
      end
      ST_PAUSE: begin
        if (stop)                       next = ST_IDLE;
        else if (step_p || !step_mode)  next = ST_FETCH;
      end
      ST_HALTED: if (start_p) next = ST_FETCH;
      default:   next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
  end

`ifdef SEQ_IO_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Held at zero outside IO_WAIT, so it always starts from zero on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   to_cnt <= '0;
    else if (state != ST_IO_WAIT) to_cnt <= '0;
    else if (!io_ack)             to_cnt <= to_cnt + 16'd1;
  end

  assign to_hit = (to_cnt == 16'(IO_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             io_err <= 1'b0;
    else if (to_fire)                       io_err <= 1'b1;
    else if (state == ST_HALTED && start_p) io_err <= 1'b0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |{16'(IO_TIMEOUT), to_fire};
  assign to_hit         = 1'b0;
  assign io_err         = 1'b0;
`endif

  assign running   = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_IO_WAIT);
  assign paused    = (state == ST_PAUSE);
  assign halted    = (state == ST_HALTED);
  assign state_dbg = state;

endmodule
